// File: rtl/gaussian_pkg.sv
// Shared widths and feeder state encoding for the gaussian datapath.
package gaussian_pkg;
    localparam int LINE_WIDTH     = 512;
    localparam int BEAT_WIDTH     = 128;
    localparam int BEATS_PER_LINE = LINE_WIDTH / BEAT_WIDTH;
    localparam int PIXEL_WIDTH    = 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_t;
endpackage

// File: rtl/gaussian_line_fifo.sv
// Line buffer between the memory read port and the beat serialiser.
module gaussian_line_fifo
    import gaussian_pkg::*;
#(
    parameter int WIDTH = LINE_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/gaussian_feeder.sv
// Serialises buffered memory lines into beats for gaussian_unit and
// appends zero flush beats after each frame.
//
//  state  | meaning
//  IDLE   | waiting for start
//  STREAM | accepting lines, issuing pixel beats
//  FLUSH  | issuing zero beats until FLUSH_BEATS sent
//  DONE   | one-cycle done pulse, then back to IDLE
module gaussian_feeder
    import gaussian_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int FLUSH_BEATS = 66
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  start,
    input  logic [31:0]           frame_beats,
    input  logic [LINE_WIDTH-1:0] line_in,
    input  logic                  line_valid,
    output logic                  line_ready,
    input  logic                  stall,
    output logic [BEAT_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  done
);
    localparam int SUB_W   = $clog2(BEATS_PER_LINE);
    localparam int FLUSH_W = $clog2(FLUSH_BEATS + 1);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    feeder_state_t         state_q;
    logic [31:0]           frame_beats_q;
    logic [31:0]           beat_cnt_q;
    logic [31:0]           lines_needed_q;
    logic [31:0]           lines_acc_q;
    logic [SUB_W-1:0]      sub_q;
    logic [FLUSH_W-1:0]    flush_cnt_q;
    logic [BEAT_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;

    logic [LINE_WIDTH-1:0] fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  push;
    logic                  pop;
    logic                  stream_issue;
    logic                  flush_issue;
    logic                  last_pixel;
    logic                  flush_last_sent;
    logic [BEAT_WIDTH-1:0] line_beats [BEATS_PER_LINE];

    for (genvar g = 0; g < BEATS_PER_LINE; g++) begin : g_beat
        assign line_beats[g] = fifo_rdata[g*BEAT_WIDTH +: BEAT_WIDTH];
    end

    assign line_ready      = (state_q == STREAM) && !fifo_full && (lines_acc_q < lines_needed_q);
    assign push            = line_valid && line_ready;
    assign last_pixel      = (beat_cnt_q == frame_beats_q - 32'd1);
    assign stream_issue    = (state_q == STREAM) && !stall && !fifo_empty;
    assign flush_last_sent = (flush_cnt_q == FLUSH_W'(FLUSH_BEATS));
    assign flush_issue     = (state_q == FLUSH) && !stall && !flush_last_sent;
    // A short last line is popped early, dropping its unused quarters.
    assign pop             = stream_issue && ((sub_q == SUB_W'(BEATS_PER_LINE - 1)) || last_pixel);

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

    gaussian_line_fifo #(
        .WIDTH (LINE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (push),
        .pop   (pop),
        .wdata (line_in),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q        <= IDLE;
            frame_beats_q  <= '0;
            beat_cnt_q     <= '0;
            lines_needed_q <= '0;
            lines_acc_q    <= '0;
            sub_q          <= '0;
            flush_cnt_q    <= '0;
            data_q         <= '0;
            valid_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            valid_q <= stream_issue || flush_issue;
            done_q  <= 1'b0;
            if (stream_issue)     data_q <= line_beats[sub_q];
            else if (flush_issue) data_q <= '0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        frame_beats_q  <= frame_beats;
                        lines_needed_q <= (frame_beats >> SUB_W) + 32'(|frame_beats[SUB_W-1:0]);
                        beat_cnt_q     <= '0;
                        lines_acc_q    <= '0;
                        sub_q          <= '0;
                        flush_cnt_q    <= '0;
                        busy_q         <= 1'b1;
                        state_q        <= (frame_beats == '0) ? FLUSH : STREAM;
                    end
                end
                STREAM: begin
                    if (push) lines_acc_q <= lines_acc_q + 32'd1;
                    if (stream_issue) begin
                        beat_cnt_q <= beat_cnt_q + 32'd1;
                        if (last_pixel) begin
                            sub_q   <= '0;
                            state_q <= FLUSH;
                        end else begin
                            sub_q <= sub_q + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // One extra FLUSH cycle lets the last beat's valid_out precede done.
                    if (flush_issue) begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    end else if (flush_last_sent) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_ready_room: assert property (@(posedge clk) disable iff (!rst_b)
        line_ready |-> (fifo_count < CNT_W'(FIFO_DEPTH)));
endmodule

// File: tb/tb_gaussian_feeder.sv
// Directed bench for gaussian_feeder: frames, stalls, FIFO back-pressure, reset.
module tb_gaussian_feeder;
    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  frame_beats = '0;
    logic [511:0] line_in = '0;
    logic         line_valid = 1'b0;
    logic         stall = 1'b0;
    logic         line_ready;
    logic [127:0] data_out;
    logic         valid_out;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    gaussian_feeder dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .start       (start),
        .frame_beats (frame_beats),
        .line_in     (line_in),
        .line_valid  (line_valid),
        .line_ready  (line_ready),
        .stall       (stall),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .busy        (busy),
        .done        (done)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [127:0] got_q [$];
    int           acc, done_cnt, hold_err, stall_err, busy_err, ready_err;
    logic         prev_rst = 1'b0;
    logic         prev_stall = 1'b0;
    logic         prev_done = 1'b0;
    logic [127:0] prev_data = '0;

    task automatic check(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [127:0] beat_val(input logic [7:0] t, input int l, input int k);
        logic [31:0] w;
        w = {8'hA5, t, l[7:0], k[7:0]};
        return {4{w}};
    endfunction

    function automatic logic [511:0] line_val(input logic [7:0] t, input int l);
        return {beat_val(t, l, 3), beat_val(t, l, 2), beat_val(t, l, 1), beat_val(t, l, 0)};
    endfunction

    // Observer: collects issued beats and flags protocol breaches each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_b && prev_rst) begin
                if (valid_out) got_q.push_back(data_out);
                else if (data_out !== prev_data) hold_err++;
                if (prev_stall && valid_out) stall_err++;
                if (done) done_cnt++;
                if (done && !busy) busy_err++;
                if (prev_done && busy) busy_err++;
                if (line_ready && !busy) ready_err++;
                if (line_valid && line_ready) acc++;
            end
            prev_rst   = rst_b;
            prev_stall = stall;
            prev_done  = done;
            prev_data  = data_out;
        end
    end

    // mode: 0 no stall, 1 stall every other cycle, 2 stall first 10 cycles.
    // abort_at > 0 asserts reset during cycle abort_at+1 and returns.
    task automatic run_frame(input int fb, input int n_offer, input int mode,
                             input logic [7:0] t, input int abort_at);
        int cyc;
        int lines_exp;
        int seq_err;
        logic [127:0] exp_b;
        got_q.delete();
        acc = 0; done_cnt = 0; hold_err = 0; stall_err = 0; busy_err = 0; ready_err = 0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 600) begin
            @(posedge clk); #1;
            start       = (cyc == 0) || (cyc == 5);
            frame_beats = (cyc == 0) ? fb : 32'd3;
            stall       = (mode == 1) ? cyc[0] : (mode == 2) ? (cyc < 10) : 1'b0;
            line_valid  = (acc < n_offer);
            line_in     = line_val(t, acc);
            @(negedge clk); #1;
            if (mode == 2 && cyc == 9) begin
                check("full_accepted", acc, 4);
                check("full_ready", line_ready, 0);
            end
            if (abort_at > 0 && cyc == abort_at) begin
                @(posedge clk); #1;
                start = 1'b0;
                #2;
                check("pre_valid", valid_out, 1);
                check("pre_busy", busy, 1);
                check("pre_ready", line_ready, 1);
                rst_b = 1'b0;
                #1;
                check("rst_valid", valid_out, 0);
                check("rst_busy", busy, 0);
                check("rst_ready", line_ready, 0);
                check("rst_data", data_out, 0);
                line_valid = 1'b0;
                repeat (2) @(negedge clk);
                @(posedge clk); #1;
                rst_b = 1'b1;
                return;
            end
            cyc++;
        end
        check("timeout", done_cnt != 0, 1);
        @(posedge clk); #1;
        start = 1'b0; stall = 1'b0; line_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        lines_exp = (fb + 3) / 4;
        if (n_offer < lines_exp) lines_exp = n_offer;
        check("nbeats", got_q.size(), fb + 66);
        seq_err = 0;
        foreach (got_q[i]) begin
            exp_b = (i < fb) ? beat_val(t, i / 4, i % 4) : '0;
            if (got_q[i] !== exp_b) seq_err++;
        end
        check("sequence", seq_err, 0);
        if (fb > 0 && got_q.size() >= fb) begin
            check("first_beat", got_q[0], beat_val(t, 0, 0));
            check("last_pixel", got_q[fb-1], beat_val(t, (fb - 1) / 4, (fb - 1) % 4));
        end
        check("lines_accepted", acc, lines_exp);
        check("done_pulses", done_cnt, 1);
        check("busy_window", busy_err, 0);
        check("hold_on_idle", hold_err, 0);
        check("stall_gap", stall_err, 0);
        check("ready_idle", ready_err, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #2;
        check("reset_data", data_out, 0);
        check("reset_valid", valid_out, 0);
        check("reset_ready", line_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;

        run_frame(8,  2, 0, 8'h01, 0);
        run_frame(6,  3, 0, 8'h02, 0);
        run_frame(16, 4, 1, 8'h03, 0);
        run_frame(24, 6, 2, 8'h04, 0);
        run_frame(0,  2, 0, 8'h05, 0);
        run_frame(32, 8, 0, 8'h06, 5);
        run_frame(4,  1, 0, 8'h07, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/gaussian_feeder.md
# gaussian_feeder

Upstream stage of `gaussian_unit`. It accepts 512-bit memory read lines over a valid/ready handshake and buffers them in a small FIFO. It serialises each line into 128-bit beats and drives them onto the unit's `data_in`/`valid_in` at one beat per cycle. After the last pixel beat of a frame it injects a fixed number of zero flush beats, which push the final rows through the unit's row buffers and output delay.

## Interface
- `LINE_WIDTH`, 512, memory line width in bits
- `BEAT_WIDTH`, 128, output beat width in bits (16 pixels × 8 bit)
- `FIFO_DEPTH`, 4, line FIFO depth in entries (power of two)
- `FLUSH_BEATS`, 66, zero beats appended after each frame
- `clk`  in  1  single clock; all flops on rising edge
- `rst_b`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse that begins a frame; ignored while `busy`
- `frame_beats`  in  32  beats in the frame; sampled on an accepted `start`
- `line_in`  in  LINE_WIDTH  memory read line
- `line_valid`  in  1  `line_in` is valid
- `line_ready`  out  1  feeder accepts `line_in` this cycle
- `stall`  in  1  downstream hold; no beat is issued while high
- `data_out`  out  BEAT_WIDTH  beat to `gaussian_unit.data_in`
- `valid_out`  out  1  to `gaussian_unit.valid_in`
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse after the last flush beat

## Operation
- **States.**
  - IDLE → STREAM on accepted `start` when `frame_beats` ≠ 0.
  - IDLE → FLUSH on accepted `start` when `frame_beats` = 0.
  - STREAM → FLUSH when the last pixel beat is issued.
  - FLUSH → DONE when the last flush beat is issued.
  - DONE → IDLE unconditionally after one cycle.
- **On accepted `start`:**
  - latch `frame_beats`;
  - compute `lines_needed` = ceil(`frame_beats`/4);
  - clear the beat, line and flush counters.
- **Line acceptance.** `line_ready` = (state == STREAM) && FIFO not full && `lines_accepted` < `lines_needed`. Transfer happens when `line_valid && line_ready`.
- **Readiness is count-based.** `line_ready` depends only on the current occupancy count. A full FIFO blocks a write even in a cycle where a pop occurs.
- **Serialisation.**
  - Beat k of a line is `line_in[128k +: 128]`, issued for k = 0..3 (least significant first).
  - The FIFO pops after beat 3, or after the final pixel beat of the frame.
  - When `frame_beats` is not a multiple of 4, the unused quarters of the last line are discarded.
- **Beat issue.**
  - STREAM: a beat is issued when `!stall` and the FIFO is non-empty.
  - FLUSH: a beat is issued when `!stall`; each flush beat has `data_out` = 0.
- **Counter widths.** Beat counter 32 bit. Flush counter is $clog2(FLUSH_BEATS+1) bits. No wrap within a frame.
- **`busy`.** High from the cycle after an accepted `start` through DONE; low in IDLE.
- **Reset.** Asserting `rst_b` at any time, including mid-frame:
  - clears FIFO pointers and counters;
  - returns the state to IDLE;
  - drives all outputs to their reset values immediately. Partial frames are dropped.

## Timing
- **Reset values:** `data_out` = 0, `valid_out` = 0, `line_ready` = 0, `busy` = 0, `done` = 0.
- **Registered outputs.** `data_out` and `valid_out` come from flops.
  - A line accepted in cycle t gives its beat 0 with `valid_out` in cycle t+2 at the earliest.
  - `line_ready` is combinational from state and registered counters only.
- **Throughput.** One beat per cycle while the FIFO is non-empty and `stall` is low. Sustained rate is 1 line per 4 cycles.
- **`stall` high in cycle t.**
  - `valid_out` = 0 in cycle t+1.
  - `data_out` holds its previous value.
  - No beat is lost or duplicated.
- **FIFO empty in STREAM.** `valid_out` = 0 and no beat is consumed. A flush does not start until all `frame_beats` beats have been issued.
- **`done`.** Asserted in the cycle after the last flush beat's `valid_out`, for exactly one cycle. `start` is accepted from the following cycle.
- **`start` timing.** `start` during STREAM, FLUSH or DONE is ignored.

## Structure
- Shared package `gaussian_pkg`: `LINE_WIDTH`, `BEAT_WIDTH`, `BEATS_PER_LINE` = LINE_WIDTH/BEAT_WIDTH, `PIXEL_WIDTH` = 8, and the state enum `feeder_state_t` {IDLE, STREAM, FLUSH, DONE}. `gaussian_unit` widths come from the same package.
- Sub-module `gaussian_line_fifo`: synchronous FIFO, `LINE_WIDTH` × `FIFO_DEPTH`, with push/pop/full/empty/count outputs. The same asynchronous active-low `rst_b` clears its pointers.
- The top level holds the FSM, the counters, the beat select mux and the output register.

## Test plan
- **Two-line frame, no stall.** `frame_beats` = 8, lines A and B, `stall` = 0 → beats A[127:0]…A[511:384], B[127:0]…B[511:384], then 66 zero beats, then one `done` pulse. 74 `valid_out` cycles in total.
- **Partial last line.** `frame_beats` = 6, source offers 3 lines → exactly 2 lines accepted. 6 pixel beats, ending with B[255:128]. `line_ready` never high for the third line. Then 66 zero beats.
- **Alternating stall.** `frame_beats` = 16, `stall` toggles every cycle → 16 pixel beats in order. `data_out` stable while stalled. No gaps or repeats in the sequence.
- **FIFO full.** `stall` held high for 10 cycles with 6 lines pending → 4 lines accepted, then `line_ready` = 0. After release, all 24 beats are issued in order.
- **Empty frame.** `frame_beats` = 0 → 66 zero beats, `done`, `busy` low next cycle, `line_ready` never high.
- **Reset mid-frame.** `rst_b` = 0 mid-stream → `valid_out`/`busy`/`line_ready` drop without waiting for a clock edge. After release, a new `start` with `frame_beats` = 4 produces the correct 4 + 66 beats.
